// File: rtl/mcdf_pkg.sv
// rtl/mcdf_pkg.sv - shared MCDF types, length constants and length decode
package mcdf_pkg;

    localparam int LEN_W = 6;

    localparam logic [LEN_W-1:0] LEN_4  = LEN_W'(4);
    localparam logic [LEN_W-1:0] LEN_8  = LEN_W'(8);
    localparam logic [LEN_W-1:0] LEN_16 = LEN_W'(16);
    localparam logic [LEN_W-1:0] LEN_32 = LEN_W'(32);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } fmt_state_e;

    // Selects above 3 are reserved and saturate to the longest packet.
    function automatic logic [LEN_W-1:0] pkglen_decode(input logic [2:0] sel);
        logic [LEN_W-1:0] len;
        case (sel)
            3'd0:    len = LEN_4;
            3'd1:    len = LEN_8;
            3'd2:    len = LEN_16;
            default: len = LEN_32;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mcdf_fmt_ctrl.sv
// rtl/mcdf_fmt_ctrl.sv - formatter FSM, word counter and handshake outputs
module mcdf_fmt_ctrl
    import mcdf_pkg::*;
#(
    parameter int LENW = LEN_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            a2f_val_i,
    input  logic [1:0]      a2f_id_i,
    input  logic [2:0]      a2f_pkglen_sel_i,
    input  logic            fmt_grant_i,
    output logic            f2a_id_req_o,
    output logic            f2a_ack_o,
    output logic            fmt_req_o,
    output logic [1:0]      fmt_chid_o,
    output logic [LENW-1:0] fmt_length_o,
    output logic            fmt_valid_o,
    output logic            fmt_start_o,
    output logic            fmt_end_o
);

    fmt_state_e      state;
    logic [LENW-2:0] cnt;
    logic [LENW-2:0] last_idx;
    logic            accept;

    // Length is at most 32, so length-1 always fits the narrower counter.
    assign last_idx = (LENW-1)'(fmt_length_o - 1'b1);
    assign accept   = a2f_val_i && f2a_ack_o;

    // State, counter and every handshake/marker output registered together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            f2a_id_req_o <= 1'b0;
            f2a_ack_o    <= 1'b0;
            fmt_req_o    <= 1'b0;
            fmt_chid_o   <= '0;
            fmt_length_o <= '0;
            fmt_valid_o  <= 1'b0;
            fmt_start_o  <= 1'b0;
            fmt_end_o    <= 1'b0;
        end else begin
            fmt_valid_o <= 1'b0;
            fmt_start_o <= 1'b0;
            fmt_end_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (a2f_val_i) begin
                        fmt_chid_o   <= a2f_id_i;
                        fmt_length_o <= LENW'(pkglen_decode(a2f_pkglen_sel_i));
                        f2a_id_req_o <= 1'b0;
                        fmt_req_o    <= 1'b1;
                        state        <= REQ;
                    end else begin
                        f2a_id_req_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (fmt_grant_i) begin
                        cnt       <= '0;
                        fmt_req_o <= 1'b0;
                        f2a_ack_o <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        fmt_valid_o <= 1'b1;
                        fmt_start_o <= (cnt == '0);
                        fmt_end_o   <= (cnt == last_idx);
                        if (cnt == last_idx) begin
                            f2a_ack_o    <= 1'b0;
                            f2a_id_req_o <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mcdf_formatter.sv
// rtl/mcdf_formatter.sv - MCDF cut-through packet formatter top
module mcdf_formatter
    import mcdf_pkg::*;
#(
    parameter int DW   = 32,
    parameter int LENW = LEN_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            f2a_id_req_o,
    output logic            f2a_ack_o,
    input  logic            a2f_val_i,
    input  logic [1:0]      a2f_id_i,
    input  logic [DW-1:0]   a2f_data_i,
    input  logic [2:0]      a2f_pkglen_sel_i,
    output logic            fmt_req_o,
    input  logic            fmt_grant_i,
    output logic [1:0]      fmt_chid_o,
    output logic [LENW-1:0] fmt_length_o,
    output logic            fmt_valid_o,
    output logic [DW-1:0]   fmt_data_o,
    output logic            fmt_start_o,
    output logic            fmt_end_o
);

    logic accept;

    assign accept = a2f_val_i && f2a_ack_o;

    mcdf_fmt_ctrl #(
        .LENW(LENW)
    ) u_ctrl (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .a2f_val_i        (a2f_val_i),
        .a2f_id_i         (a2f_id_i),
        .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
        .fmt_grant_i      (fmt_grant_i),
        .f2a_id_req_o     (f2a_id_req_o),
        .f2a_ack_o        (f2a_ack_o),
        .fmt_req_o        (fmt_req_o),
        .fmt_chid_o       (fmt_chid_o),
        .fmt_length_o     (fmt_length_o),
        .fmt_valid_o      (fmt_valid_o),
        .fmt_start_o      (fmt_start_o),
        .fmt_end_o        (fmt_end_o)
    );

    // Single output stage: capture each accepted word, hold it through bubbles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fmt_data_o <= '0;
        end else if (accept) begin
            fmt_data_o <= a2f_data_i;
        end
    end

endmodule

// File: tb/tb_mcdf_formatter.sv
// tb/tb_mcdf_formatter.sv - directed self-checking bench for mcdf_formatter
module tb_mcdf_formatter;

    localparam int DW   = 32;
    localparam int LENW = 6;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            f2a_id_req_o;
    logic            f2a_ack_o;
    logic            a2f_val_i;
    logic [1:0]      a2f_id_i;
    logic [DW-1:0]   a2f_data_i;
    logic [2:0]      a2f_pkglen_sel_i;
    logic            fmt_req_o;
    logic            fmt_grant_i;
    logic [1:0]      fmt_chid_o;
    logic [LENW-1:0] fmt_length_o;
    logic            fmt_valid_o;
    logic [DW-1:0]   fmt_data_o;
    logic            fmt_start_o;
    logic            fmt_end_o;

    mcdf_formatter #(.DW(DW), .LENW(LENW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .f2a_id_req_o     (f2a_id_req_o),
        .f2a_ack_o        (f2a_ack_o),
        .a2f_val_i        (a2f_val_i),
        .a2f_id_i         (a2f_id_i),
        .a2f_data_i       (a2f_data_i),
        .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
        .fmt_req_o        (fmt_req_o),
        .fmt_grant_i      (fmt_grant_i),
        .fmt_chid_o       (fmt_chid_o),
        .fmt_length_o     (fmt_length_o),
        .fmt_valid_o      (fmt_valid_o),
        .fmt_data_o       (fmt_data_o),
        .fmt_start_o      (fmt_start_o),
        .fmt_end_o        (fmt_end_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int stray = 0;
    int first_acc_cyc = 0;

    logic [DW-1:0]   q_data[$];
    logic            q_start[$];
    logic            q_end[$];
    logic            q_idreq[$];
    logic [1:0]      q_chid[$];
    logic [LENW-1:0] q_len[$];
    int              q_cyc[$];

    always @(posedge clk_i) cyc_cnt++;

    // Output monitor: records every valid word with its sidebands.
    always @(negedge clk_i) begin
        if (!rst_i && fmt_valid_o) begin
            q_data.push_back(fmt_data_o);
            q_start.push_back(fmt_start_o);
            q_end.push_back(fmt_end_o);
            q_idreq.push_back(f2a_id_req_o);
            q_chid.push_back(fmt_chid_o);
            q_len.push_back(fmt_length_o);
            q_cyc.push_back(cyc_cnt);
        end
        if (!rst_i && !fmt_valid_o && (fmt_start_o || fmt_end_o)) stray++;
    end

    function automatic logic [45:0] outs();
        return {f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_valid_o, fmt_start_o,
                fmt_end_o, fmt_chid_o, fmt_length_o, fmt_data_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_start.delete(); q_end.delete(); q_idreq.delete();
        q_chid.delete(); q_len.delete(); q_cyc.delete();
        stray = 0;
    endtask

    task automatic drive_packet(input logic [1:0] id, input logic [2:0] sel,
                                input logic [31:0] base, input int n, input int gap_every,
                                input int grant_delay, input bit hold_grant,
                                input bit toggle_id, input bit keep_val);
        int  w;
        int  c;
        int  guard;
        bit  acc;
        a2f_val_i = 1'b1;
        a2f_id_i = id;
        a2f_pkglen_sel_i = sel;
        a2f_data_i = base;
        guard = 0;
        while (!fmt_req_o && guard < 20) begin
            step();
            guard++;
        end
        if (!fmt_req_o) begin
            checks++; errors++;
            $display("FAIL req_timeout: fmt_req_o=%0b required 1", fmt_req_o);
        end
        for (int i = 0; i < grant_delay; i++) begin
            if (toggle_id) a2f_id_i = ~id;
            step();
        end
        fmt_grant_i = 1'b1;
        step();
        if (!hold_grant) fmt_grant_i = 1'b0;
        w = 0;
        c = 0;
        guard = 0;
        while (w < n && guard < 400) begin
            a2f_val_i = !(gap_every > 0 && (c % gap_every) == gap_every - 1);
            a2f_data_i = base + w;
            if (toggle_id) a2f_id_i = 2'(c);
            acc = a2f_val_i && f2a_ack_o;
            step();
            if (acc) begin
                if (w == 0) first_acc_cyc = cyc_cnt;
                w++;
            end
            c++;
            guard++;
        end
        if (w != n) begin
            checks++; errors++;
            $display("FAIL accept_timeout: accepted=%0d required %0d", w, n);
        end
        if (!keep_val) a2f_val_i = 1'b0;
        a2f_id_i = id;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step(); step();
        checks++;
        if (outs() !== 46'd0) begin
            errors++;
            $display("FAIL reset_outs: got %h required 0", outs());
        end
        rst_i = 1'b0;
        step(); step();
        checks++;
        if (outs() !== {1'b1, 45'd0}) begin
            errors++;
            $display("FAIL idle_outs: got %h required %h", outs(), {1'b1, 45'd0});
        end
    endtask

    task automatic test_basic();
        clear_q();
        drive_packet(2'd1, 3'd0, 32'h00C1_0000, 4, 0, 2, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        checks++;
        if (q_data.size() !== 4) begin
            errors++;
            $display("FAIL basic_count: got %0d required 4", q_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({q_data[i], q_chid[i], q_len[i], q_start[i], q_end[i], q_idreq[i]} !==
                    {32'h00C1_0000 + 32'(i), 2'd1, 6'd4, i == 0, i == 3, i == 3}) begin
                    errors++;
                    $display("FAIL basic_word%0d: data=%h chid=%0d len=%0d s=%0b e=%0b idreq=%0b",
                             i, q_data[i], q_chid[i], q_len[i], q_start[i], q_end[i], q_idreq[i]);
                end
            end
            checks++;
            if (q_cyc[0] !== first_acc_cyc) begin
                errors++;
                $display("FAIL basic_latency: out cycle %0d required %0d", q_cyc[0], first_acc_cyc);
            end
        end
    endtask

    task automatic test_gaps();
        clear_q();
        drive_packet(2'd2, 3'd3, 32'h00C2_0000, 32, 3, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        checks++;
        if (q_data.size() !== 32) begin
            errors++;
            $display("FAIL gaps_count: got %0d required 32", q_data.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if ({q_data[i], q_chid[i], q_len[i], q_start[i], q_end[i]} !==
                    {32'h00C2_0000 + 32'(i), 2'd2, 6'd32, i == 0, i == 31}) begin
                    errors++;
                    $display("FAIL gaps_word%0d: data=%h chid=%0d len=%0d s=%0b e=%0b",
                             i, q_data[i], q_chid[i], q_len[i], q_start[i], q_end[i]);
                end
            end
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL gaps_stray_markers: got %0d required 0", stray);
        end
    endtask

    task automatic test_len_and_hold_grant();
        clear_q();
        drive_packet(2'd0, 3'd6, 32'h00C6_0000, 32, 0, 1, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        checks++;
        if (q_data.size() !== 32 || q_len[0] !== 6'd32 || q_end[31] !== 1'b1) begin
            errors++;
            $display("FAIL sel6_len: words=%0d len=%0d required 32 words len 32 with end",
                     q_data.size(), q_len.size() > 0 ? q_len[0] : 6'd0);
        end
        clear_q();
        fmt_grant_i = 1'b1;
        repeat (3) step();
        checks++;
        if ({fmt_req_o, f2a_ack_o, f2a_id_req_o} !== 3'b001) begin
            errors++;
            $display("FAIL hold_idle: req/ack/idreq=%b required 001", {fmt_req_o, f2a_ack_o, f2a_id_req_o});
        end
        drive_packet(2'd0, 3'd2, 32'h00D0_0000, 16, 0, 0, 1'b1, 1'b0, 1'b0);
        repeat (8) step();
        fmt_grant_i = 1'b0;
        checks++;
        if (q_data.size() !== 16 || q_len[0] !== 6'd16 || q_data[15] !== 32'h00D0_000F
            || q_end[15] !== 1'b1) begin
            errors++;
            $display("FAIL hold_words: words=%0d required 16 ending 00d0000f", q_data.size());
        end
        checks++;
        if ({fmt_req_o, f2a_ack_o, f2a_id_req_o} !== 3'b001) begin
            errors++;
            $display("FAIL hold_no_repeat: req/ack/idreq=%b required 001", {fmt_req_o, f2a_ack_o, f2a_id_req_o});
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        drive_packet(2'd0, 3'd1, 32'h00A0_0000, 8, 0, 0, 1'b0, 1'b0, 1'b1);
        drive_packet(2'd1, 3'd0, 32'h00B1_0000, 4, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        checks++;
        if (q_data.size() !== 12) begin
            errors++;
            $display("FAIL b2b_count: got %0d required 12", q_data.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if ({q_data[i], q_chid[i], q_len[i], q_end[i]} !==
                    (i < 8 ? {32'h00A0_0000 + 32'(i), 2'd0, 6'd8, i == 7}
                           : {32'h00B1_0000 + 32'(i - 8), 2'd1, 6'd4, i == 11})) begin
                    errors++;
                    $display("FAIL b2b_word%0d: data=%h chid=%0d len=%0d e=%0b",
                             i, q_data[i], q_chid[i], q_len[i], q_end[i]);
                end
            end
            checks++;
            if (q_cyc[8] - q_cyc[7] !== 3) begin
                errors++;
                $display("FAIL b2b_gap: got %0d cycles required 3", q_cyc[8] - q_cyc[7]);
            end
        end
    endtask

    task automatic test_id_toggle();
        bit req_seen;
        clear_q();
        req_seen = 1'b0;
        fmt_grant_i = 1'b1;
        step();
        fmt_grant_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (fmt_req_o) req_seen = 1'b1;
            step();
        end
        checks++;
        if (req_seen || !f2a_id_req_o) begin
            errors++;
            $display("FAIL idle_grant: req_seen=%0b idreq=%0b required 0 and 1", req_seen, f2a_id_req_o);
        end
        drive_packet(2'd2, 3'd0, 32'h00C3_0000, 4, 0, 1, 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        checks++;
        if (q_data.size() !== 4) begin
            errors++;
            $display("FAIL toggle_count: got %0d required 4", q_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({q_data[i], q_chid[i], q_len[i]} !== {32'h00C3_0000 + 32'(i), 2'd2, 6'd4}) begin
                    errors++;
                    $display("FAIL toggle_word%0d: data=%h chid=%0d len=%0d", i, q_data[i], q_chid[i], q_len[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int ends;
        clear_q();
        a2f_val_i = 1'b1;
        a2f_id_i = 2'd1;
        a2f_pkglen_sel_i = 3'd3;
        a2f_data_i = 32'hDEAD_0000;
        guard = 0;
        while (!fmt_req_o && guard < 20) begin
            step();
            guard++;
        end
        fmt_grant_i = 1'b1;
        step();
        fmt_grant_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a2f_data_i = 32'hDEAD_0000 + 32'(i);
            step();
        end
        #3;
        rst_i = 1'b1;
        #1;
        checks++;
        if (outs() !== 46'd0) begin
            errors++;
            $display("FAIL async_reset: got %h required 0", outs());
        end
        a2f_val_i = 1'b0;
        step();
        rst_i = 1'b0;
        step(); step();
        ends = 0;
        foreach (q_end[i]) if (q_end[i]) ends++;
        checks++;
        if (ends !== 0 || q_data.size() !== 4) begin
            errors++;
            $display("FAIL abort_words: words=%0d ends=%0d required 4 and 0", q_data.size(), ends);
        end
        checks++;
        if (outs() !== {1'b1, 45'd0}) begin
            errors++;
            $display("FAIL post_abort_idle: got %h required %h", outs(), {1'b1, 45'd0});
        end
    endtask

    initial begin
        rst_i = 1'b1;
        a2f_val_i = 1'b0;
        a2f_id_i = 2'd0;
        a2f_data_i = '0;
        a2f_pkglen_sel_i = 3'd0;
        fmt_grant_i = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_len_and_hold_grant();
        test_back_to_back();
        test_id_toggle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcdf_formatter.md
Name: mcdf_formatter

Overview:
- Downstream stage of the MCDF channel arbiter.
- Requests a channel ID from the arbiter, latches that channel's packet length selection, then arbitrates for the output bus.
- Once granted, streams exactly the selected number of data words, framed with start/end markers and a channel ID.
- Cut-through design: one registered output stage, no packet buffer.

Parameters:
- DW, 32, data word width (arbiter and output data).
- LENW, 6, width of the length field (must hold the value 32).

Ports:
- clk_i  in  1  system clock, all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- f2a_id_req_o  out  1  request to the arbiter for the next packet's channel ID.
- f2a_ack_o  out  1  word accept; a word transfers when a2f_val_i && f2a_ack_o.
- a2f_val_i  in  1  arbiter data/ID valid.
- a2f_id_i  in  2  channel ID of the offered packet (0..2; 3 passed through unchecked).
- a2f_data_i  in  DW  data word.
- a2f_pkglen_sel_i  in  3  packet length select.
- fmt_req_o  out  1  output bus request.
- fmt_grant_i  in  1  output bus grant.
- fmt_chid_o  out  2  channel ID of the current packet.
- fmt_length_o  out  LENW  packet length in words.
- fmt_valid_o  out  1  fmt_data_o holds a valid word this cycle.
- fmt_data_o  out  DW  output data word.
- fmt_start_o  out  1  marks the first word of a packet.
- fmt_end_o  out  1  marks the last word of a packet.

Behaviour:
- Reset: every output is 0; FSM = IDLE; word counter = 0. Reset asserted mid-packet aborts the packet; no end marker is produced.
- Length decode of a2f_pkglen_sel_i: 0→4, 1→8, 2→16, 3→32, 4..7→32.
- FSM states: IDLE, REQ, SEND.
- IDLE:
  - f2a_id_req_o = 1 and f2a_ack_o = 0.
  - When a2f_val_i = 1: latch a2f_id_i into fmt_chid_o and the decoded length into fmt_length_o, then go to REQ.
  - The word on the bus is not consumed in IDLE; it stays offered.
- REQ:
  - fmt_req_o = 1; f2a_id_req_o = 0; f2a_ack_o = 0.
  - fmt_grant_i = 1 → clear the counter and go to SEND. fmt_req_o drops the cycle after the grant is sampled.
  - a2f_val_i and a2f_id_i changes are ignored in this state.
- SEND:
  - f2a_ack_o = 1 (registered level, high for the whole state).
  - Each cycle with a2f_val_i = 1, the word is accepted. Next cycle: fmt_valid_o = 1, fmt_data_o = word, fmt_start_o = (cnt == 0), fmt_end_o = (cnt == length−1). The counter then increments.
  - Cycles with a2f_val_i = 0 insert bubbles: fmt_valid_o, fmt_start_o and fmt_end_o are all 0; the counter holds.
  - After the last word is accepted, f2a_ack_o drops in the next cycle and the FSM returns to IDLE in that same cycle.
  - fmt_end_o and the first IDLE cycle (f2a_id_req_o = 1) therefore coincide.
- fmt_chid_o and fmt_length_o stay stable from the REQ entry until the next IDLE latch.
- fmt_grant_i outside REQ is ignored.
- Latency: one cycle from word accept to output word.
- Minimum gap between packets: 1 IDLE cycle plus the REQ cycles (at least 1).
- Counter: LENW-1 bits, compared against length−1; no wrap, since the state exits at the last word.
- a2f_id_i changing during SEND is ignored; the ID was latched in IDLE.

Decomposition:
- Shared package mcdf_pkg:
  - fmt_state_e enum (IDLE/REQ/SEND);
  - LEN_4/8/16/32 constants;
  - function pkglen_decode(sel) returning a LENW value, shared with the arbiter and the scoreboard.
- One sub-module is natural: mcdf_fmt_ctrl (FSM, counter, handshake outputs).
- The data register stays in mcdf_formatter.

Test Plan:
- Reset, then idle: f2a_id_req_o = 1 and all other outputs 0. Assert rst_i mid-SEND → all outputs 0 within the same cycle (asynchronous).
- a2f_val_i = 1, id = 1, sel = 0, grant 2 cycles after fmt_req_o, data 0x00C1_0000..03 back-to-back → 4 fmt_valid_o words with chid = 1, length = 4; start on 0x00C1_0000, end on 0x00C1_0003; f2a_id_req_o rises with the end.
- id = 2, sel = 3 with valid gaps every 3rd cycle → exactly 32 valid words, 0x00C2_0000..1F; markers only on valid cycles; the counter holds during gaps.
- sel = 6 → fmt_length_o = 32; sel = 2 → 16 words. Grant held high continuously → accepted only in REQ, with no spurious repeat packet.
- Back-to-back packets ch0 (sel = 1) then ch1 (sel = 0) → 8 then 4 words, chid switches only after fmt_end_o, with the 1-cycle IDLE gap observed.
- a2f_id_i toggled during SEND and grant pulsed in IDLE → chid and length unchanged; no fmt_req_o glitch.
